// File: rtl/riscv_pkg.sv
// Shared encodings for the fetch stage and control_unit: PCSrc values, NOP word, fetch FSM states.
package riscv_pkg;

    localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
    localparam logic [1:0] PCSRC_TARGET = 2'b01;
    localparam logic [1:0] PCSRC_ALU    = 2'b10;
    localparam logic [1:0] PCSRC_RSVD   = 2'b11;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection from PCSrc; flags a misaligned branch/jal target or a reserved PCSrc.
module pc_next_sel
    import riscv_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  pcsrc,
    input  logic [31:0] immext,
    input  logic [31:0] aluresult,
    output logic [31:0] next_pc,
    output logic [31:0] pc_plus4,
    output logic        err
);

    logic [31:0] target;
    logic [31:0] alu_target;

    assign pc_plus4   = pc + 32'd4;
    assign target     = pc + immext;
    // jalr clears bit 0 architecturally; bit 1 is also dropped to keep fetches word aligned
    assign alu_target = aluresult & ~32'h3;

    always_comb begin
        next_pc = pc_plus4;
        err     = 1'b0;
        case (pcsrc)
            PCSRC_PLUS4: begin
                next_pc = pc_plus4;
            end
            PCSRC_TARGET: begin
                next_pc = {target[31:2], 2'b00};
                err     = |target[1:0];
            end
            PCSRC_ALU: begin
                next_pc = alu_target;
            end
            default: begin
                next_pc = pc_plus4;
                err     = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: holds PC, fetches one instruction word per req/ready + rvalid exchange, and
// presents Instr/PC until the datapath consumes it, then advances PC from PCSrc.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] ImmExt,
    input  logic [31:0] ALUResult,
    output logic        fetch_err,
    output logic [1:0]  fsm_state
);

    // Handshakes: a request transfers on a cycle with imem_req & imem_ready; the word returns
    // later on imem_rvalid (only honoured in S_WAIT); Instr is consumed on instr_valid & instr_ready.

    fetch_state_t state_q, state_d;
    logic [31:0]  next_pc;
    logic         sel_err;
    logic         accept;
    logic         consume;

    pc_next_sel u_pc_next_sel (
        .pc        (PC),
        .pcsrc     (PCSrc),
        .immext    (ImmExt),
        .aluresult (ALUResult),
        .next_pc   (next_pc),
        .pc_plus4  (PCPlus4),
        .err       (sel_err)
    );

    assign fsm_state = state_q;
    assign imem_addr = PC;
    assign accept    = (state_q == S_WAIT) && imem_rvalid;
    assign consume   = (state_q == S_HOLD) && instr_ready;

    always_comb begin
        state_d  = state_q;
        // gated by rst_n so no request escapes while the core is held in reset
        imem_req = (state_q == S_REQ) && rst_n;
        case (state_q)
            S_REQ:   if (imem_ready) state_d = S_WAIT;
            S_WAIT:  if (imem_rvalid) state_d = S_HOLD;
            S_HOLD:  if (instr_ready) state_d = S_REQ;
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_REQ;
            PC          <= RESET_PC;
            Instr       <= NOP_WORD;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                Instr       <= imem_rdata;
                instr_valid <= 1'b1;
            end
            if (consume) begin
                PC          <= next_pc;
                Instr       <= NOP_WORD;
                instr_valid <= 1'b0;
                fetch_err   <= fetch_err | sel_err;
            end
        end
    end

endmodule
